// File: rtl/mem_pkg.sv
// Shared layout of the memory request word and write-back bus.
// The issuer and the memory unit both import this package.
package mem_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 16;
  localparam int RD_W     = 3;
  localparam int REQ_W    = 27;
  localparam int NUM_REGS = 2 ** RD_W;

  localparam int REQ_ADDR_LSB      = 0;
  localparam int REQ_VALUE_LSB     = 5;
  localparam int REQ_LOAD_BIT      = 21;
  localparam int REQ_MEM_WRITE_BIT = 22;
  localparam int REQ_WRITE_BIT     = 23;
  localparam int REQ_RD_LSB        = 24;

  localparam int WB_EN_BIT = 0;
  localparam int WB_RD_LSB = 1;
  localparam int WB_W      = 1 + RD_W;

  // Members are listed MSB first so the struct matches the bit positions above.
  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic              is_write;
    logic              is_mem_write;
    logic              is_load;
    logic [DATA_W-1:0] value;
    logic [ADDR_W-1:0] addr;
  } mem_req_t;

  // A store never loads and never writes a register, even if decode says so.
  function automatic mem_req_t pack_req(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] value,
    input logic [RD_W-1:0]   rd,
    input logic              is_load,
    input logic              is_store,
    input logic              reg_write
  );
    mem_req_t r;
    r.addr         = addr;
    r.value        = value;
    r.rd           = rd;
    r.is_load      = is_load & ~is_store;
    r.is_mem_write = is_store;
    r.is_write     = reg_write & ~is_store;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small in-order FIFO with occupancy count; full/empty come from the count.
// flush empties it and drops any push arriving in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_req_issuer.sv
// Issue-side front end: queues decoded ops, issues one packed request per cycle,
// and tracks registers with a write in flight until the memory unit writes back.
module mem_req_issuer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_value,
  input  logic [RD_W-1:0]        in_rd,
  input  logic                   in_is_load,
  input  logic                   in_is_store,
  input  logic                   in_reg_write,
  input  logic                   mem_stall,
  input  logic                   flush,
  output logic                   req_valid,
  output logic [REQ_W-1:0]       req,
  input  logic                   wb_en,
  input  logic [RD_W-1:0]        wb_rd,
  output logic [NUM_REGS-1:0]    rd_busy,
  output logic [$clog2(DEPTH):0] count
);

  mem_req_t             in_req;
  mem_req_t             head;
  logic [REQ_W-1:0]     head_word;
  logic                 full;
  logic                 empty;
  logic                 issue;
  logic [NUM_REGS-1:0]  busy_next;

  assign in_req   = pack_req(in_addr, in_value, in_rd, in_is_load, in_is_store, in_reg_write);
  assign head     = mem_req_t'(head_word);
  assign in_ready = ~full;
  assign issue    = ~empty & ~mem_stall & ~flush;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (issue),
    .flush (flush),
    .din   (in_req),
    .dout  (head_word),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Setting comes after clearing so an issue beats a same-cycle write-back.
  always_comb begin
    busy_next = rd_busy;
    if (wb_en) busy_next[wb_rd] = 1'b0;
    if (issue && head.is_write) busy_next[head.rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      req       <= '0;
      rd_busy   <= '0;
    end else begin
      req_valid <= issue;
      if (issue) req <= head_word;
      rd_busy   <= busy_next;
    end
  end

endmodule
